// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit path.
package uart_pkg;
    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    function automatic int calc_baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word fall-through FIFO with full/empty/count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             push, pop;

    assign full    = count == (AW + 1)'(DEPTH);
    assign empty   = count == '0;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rptr];

    always_ff @(posedge CLOCK_50)
        if (push) mem[wptr] <= wr_data;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLOCK_50 or negedge RESET_n)
        if (!RESET_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            if (push != pop) count <= push ? count + (AW + 1)'(1) : count - (AW + 1)'(1);
        end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_n,
    input  logic [UART_DATA_W-1:0]        tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    tx_state_t              state;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shift, fifo_data;
    logic                   full, empty, pop, tick;
`ifdef UART_TX_PARITY_EN
    logic                   par;
`endif

    sync_fifo #(.WIDTH(UART_DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLOCK_50 (CLOCK_50),
        .RESET_n  (RESET_n),
        .wr_en    (tx_valid),
        .wr_data  (tx_data),
        .rd_en    (pop),
        .rd_data  (fifo_data),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    assign tx_ready = !full;
    assign tick     = cnt == LAST;
    assign pop      = !empty && (state == IDLE || (state == STOP && tick));
    assign busy     = state != IDLE || fifo_count != '0;

    always_ff @(posedge CLOCK_50 or negedge RESET_n)
        if (!RESET_n) overflow <= 1'b0;
        else if (tx_valid && !tx_ready) overflow <= 1'b1;

    // Popping in IDLE or at the end of STOP chains frames with no idle gap.
    always_ff @(posedge CLOCK_50 or negedge RESET_n)
        if (!RESET_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_txd <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            cnt <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
            if (pop) begin
                state    <= START;
                shift    <= fifo_data;
                uart_txd <= 1'b0;
`ifdef UART_TX_PARITY_EN
                par      <= ^fifo_data;
`endif
            end else if (tick) begin
                case (state)
                    START: begin
                        state    <= DATA;
                        bit_idx  <= '0;
                        uart_txd <= shift[0];
                        shift    <= shift >> 1;
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            uart_txd <= par;
`else
                            state    <= STOP;
                            uart_txd <= 1'b1;
`endif
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            uart_txd <= shift[0];
                            shift    <= shift >> 1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state    <= STOP;
                        uart_txd <= 1'b1;
                    end
`endif
                    STOP: begin
                        state    <= IDLE;
                        uart_txd <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo at BAUD_DIV=10.
// Follows UART_TX_PARITY_EN to select the 10- or 11-bit frame.
module tb_uart_tx_fifo;
    localparam int BD = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * BD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, uart_txd, busy, overflow;
    logic [4:0] fifo_count;
    logic [7:0] eb [0:16];
    int         tests = 0;
    int         fails = 0;

    uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(16)) dut (
        .CLOCK_50   (clk),
        .RESET_n    (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_txd   (uart_txd),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Expected line level s clocks after the accept edge, frames back to back from eb[].
    function automatic logic exp_line(input int s);
        int f, bi;
        logic [7:0] b;
        f  = (s - 1) / FL;
        bi = ((s - 1) % FL) / BD;
        b  = eb[f];
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
`ifdef UART_TX_PARITY_EN
        if (bi == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic line_check(input int first, input int last);
        for (int s = first; s <= last; s++) begin
            @(negedge clk);
            chk($sformatf("line@%0d", s), uart_txd, exp_line(s));
        end
    endtask

    task automatic push(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_txd", uart_txd, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle_txd", uart_txd, 1);
        end
        chk("idle_busy", busy, 0);

        eb[0] = 8'hA5;
        push(8'hA5);
        chk("a5_count", fifo_count, 1);
        chk("a5_busy", busy, 1);
        chk("a5_txd_accept", uart_txd, 1);
        line_check(1, FL);
        chk("a5_busy_last", busy, 1);
        @(negedge clk);
        chk("a5_busy_drop", busy, 0);
        chk("a5_idle_txd", uart_txd, 1);

        eb[0] = 8'h00; eb[1] = 8'hFF; eb[2] = 8'h55;
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(negedge clk);
        chk("b2b_count0", fifo_count, 1);
        tx_data = 8'hFF;
        @(negedge clk);
        chk("b2b_count1", fifo_count, 1);
        chk("b2b_line1", uart_txd, 0);
        tx_data = 8'h55;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("b2b_count2", fifo_count, 2);
        chk("b2b_line2", uart_txd, 0);
        line_check(3, FL);
        chk("b2b_pre_pop1", fifo_count, 2);
        line_check(FL + 1, FL + 1);
        chk("b2b_pop1", fifo_count, 1);
        line_check(FL + 2, 2 * FL);
        chk("b2b_pre_pop2", fifo_count, 1);
        line_check(2 * FL + 1, 2 * FL + 1);
        chk("b2b_pop2", fifo_count, 0);
        line_check(2 * FL + 2, 3 * FL);
        chk("b2b_busy_last", busy, 1);
        @(negedge clk);
        chk("b2b_busy_drop", busy, 0);

        eb[0] = 8'h11;
        for (int i = 0; i < 16; i++) eb[i+1] = 8'(8'h20 + i);
        push(8'h11);
        line_check(1, 4);
        chk("full_start_count", fifo_count, 0);
        for (int i = 0; i < 17; i++) begin
            chk("full_ready_pre", tx_ready, (i < 16) ? 1 : 0);
            chk("full_ovf_pre", overflow, 0);
            tx_valid = 1'b1;
            tx_data  = 8'(8'h20 + i);
            @(negedge clk);
            chk($sformatf("line@%0d", 5 + i), uart_txd, exp_line(5 + i));
            chk("full_count", fifo_count, (i < 16) ? i + 1 : 16);
        end
        tx_valid = 1'b0;
        chk("full_ovf_set", overflow, 1);
        chk("full_ready_low", tx_ready, 0);
        line_check(22, 17 * FL);
        chk("drain_count", fifo_count, 0);
        @(negedge clk);
        chk("drain_busy", busy, 0);
        chk("drain_ovf_sticky", overflow, 1);
        chk("drain_ready", tx_ready, 1);

        eb[0] = 8'hF0;
        push(8'hF0);
        tx_valid = 1'b1;
        tx_data  = 8'h0F;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("mid_count_pre", fifo_count, 1);
        line_check(2, 45);
        chk("mid_bit3_low", uart_txd, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", uart_txd, 1);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * FL) begin
            @(negedge clk);
            chk("post_rst_txd", uart_txd, 1);
        end
        chk("post_rst_busy", busy, 0);

`ifdef UART_TX_PARITY_EN
        eb[0] = 8'h07;
        push(8'h07);
        line_check(1, 9 * BD);
        @(negedge clk);
        chk("par07_bit", uart_txd, 1);
        line_check(9 * BD + 2, FL);
        chk("par07_busy_last", busy, 1);
        @(negedge clk);
        chk("par07_busy_drop", busy, 0);
        eb[0] = 8'h03;
        push(8'h03);
        line_check(1, 9 * BD);
        @(negedge clk);
        chk("par03_bit", uart_txd, 0);
        line_check(9 * BD + 2, FL);
        @(negedge clk);
        chk("par03_busy_drop", busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
